scene_sequencer: RTL and testbench
==================================

// Module: scene_sequencer
// PURPOSE
//  Game-level controller for the scene renderer. Owns the game FSM (INITIAL/PLAYING/OVER),
//  generates the 100 Hz game tick from clk, and produces the ground scroll offset, scroll
//  speed and BCD score. Offset is published only on frame_start so a frame never tears.
// PARAMETERS
//  TICK_DIV        250000  clk cycles per game tick (25 MHz -> 100 Hz)
//  GROUND_SIZE_X   1200    ground strip width in pixels; offset wraps modulo this
//  SPEED_INIT      3       pixels/tick at game start
//  SPEED_MAX       8       speed ceiling
//  SCORE_DIV       10      ticks per score point
//  OVER_HOLD_TICKS 50      ticks after game over during which start presses are ignored
// PORTS
//  clk          in   1   system clock (pixel clock domain)
//  rst_n        in   1   synchronous reset, active low
//  btn_start    in   1   start/jump button level, already synchronised to clk
//  collision    in   1   level from sprite logic, high while the player overlaps an obstacle
//  frame_start  in   1   1-cycle pulse at the start of vertical blanking
//  game_state   out  2   0=INITIAL 1=PLAYING 2=OVER
//  ground_offset out 11  published scroll offset, 0..GROUND_SIZE_X-1
//  speed        out  4   current pixels/tick
//  score        out  16  4-digit BCD, saturates at 16'h9999
//  tick         out  1   1-cycle game tick pulse, for other game-logic blocks
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge, overrides everything, including mid-game): state INITIAL,
//   ground_offset=0, offset_pend=0, speed=SPEED_INIT, score=0, tick=0, divider=0, btn_q=0, hold=0.
//  Tick: divider counts 0..TICK_DIV-1; tick=1 for exactly the cycle after divider==TICK_DIV-1.
//   Runs in every state.
//  press = btn_start & ~btn_q (rising edge; btn_q is btn_start delayed by one cycle).
//   A held button produces one press.
//  FSM (registered, 1-cycle latency; press at edge k -> new game_state visible after edge k):
//   INITIAL: press -> PLAYING; clear score, score_div, offset_pend; speed=SPEED_INIT.
//   PLAYING: collision -> OVER, hold=0. Collision beats a coincident tick: that tick does not
//    advance offset or score. Otherwise on tick: offset_pend advances, score_div counts.
//   OVER: offset_pend, score and speed frozen. hold counts ticks and saturates at
//    OVER_HOLD_TICKS. A press while hold<OVER_HOLD_TICKS is dropped and not queued.
//    A press after that -> PLAYING with the same clears as INITIAL->PLAYING.
//   State 3 (illegal) -> INITIAL on the next edge.
//  Offset arithmetic: 12-bit sum s = offset_pend + speed. If s >= GROUND_SIZE_X, the new value
//   is s - GROUND_SIZE_X; otherwise it is s. The remainder wraps exactly (it is not forced to 0).
//  Publication: ground_offset <= offset_pend only on frame_start. If frame_start and tick fall
//   in the same cycle, ground_offset takes the pre-tick value.
//  Score: score_div counts ticks 0..SCORE_DIV-1; on wrap, score increments in BCD with digit
//   carry. At 9999 score holds. When a BCD increment carries into the hundreds digit, speed
//   increments by 1, capped at SPEED_MAX.
// STRUCTURE
//  Shared package scene_pkg (scene_defs.vh): GAME_INITIAL/PLAYING/OVER encodings and
//   GROUND_SIZE_X, also used by the scene display and sprite blocks.
//  Sub-module tick_gen #(TICK_DIV): clk, rst_n -> tick. FSM, offset, BCD score stay in top.
// TESTING (TICK_DIV=4, frame_start on every tick cycle unless stated)
//  1 Reset: rst_n low 3 cycles -> state 0, offset 0, speed 3, score 0, tick 0;
//    btn_start held through reset and then released gives no start.
//  2 Scroll/wrap: press, then 400 ticks -> ground_offset 0,3,...,1197, then 0.
//    Force speed 4 at offset_pend 1198 -> next value 2.
//  3 Score/speed: 1000 ticks of play -> score=16'h0100 and speed 4; at 16'h9999 score holds
//    and speed stays at or below 8.
//  4 Collision on the same cycle as tick at offset 300, score 0x0042 -> state 2,
//    offset stays 300, score stays 0x0042.
//  5 Lockout: press 10 ticks into OVER -> stays OVER; press after 50 ticks -> PLAYING,
//    score 0, ground_offset 0 after the next frame_start.
//  6 Tear-free and reset: frame_start every 7 ticks -> ground_offset changes only on the cycle
//    after frame_start; rst_n low mid-PLAYING -> all reset values after that edge.

Source files
------------

// File: rtl/scene_pkg.sv
// Shared game definitions for the scene sequencer, display and sprite blocks.
package scene_pkg;

    // Game FSM encodings as seen on the game_state port.
    typedef enum logic [1:0] {
        GameInitial = 2'd0,
        GamePlaying = 2'd1,
        GameOver    = 2'd2
    } game_state_e;

    localparam int unsigned GROUND_SIZE_X = 1200;

    // 4-digit BCD increment with per-digit carry; 9999 rolls to 0000 (caller saturates).
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Game tick generator: one-cycle pulse every TICK_DIV clk cycles.
module tick_gen #(
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned   DivW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

    logic [DivW-1:0] div_q;
    logic            tick_q;

    // Divider wraps at TICK_DIV-1; tick is high the cycle after the wrap value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (div_q == DivLast);
            div_q  <= (div_q == DivLast) ? '0 : div_q + DivW'(1);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/scene_sequencer.sv
// Game-level controller: game FSM, scroll offset, speed and BCD score.
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 250000,
    parameter int unsigned GROUND_SIZE_X   = scene_pkg::GROUND_SIZE_X,
    parameter int unsigned SPEED_INIT      = 3,
    parameter int unsigned SPEED_MAX       = 8,
    parameter int unsigned SCORE_DIV       = 10,
    parameter int unsigned OVER_HOLD_TICKS = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        collision,
    input  logic        frame_start,
    output logic [1:0]  game_state,
    output logic [10:0] ground_offset,
    output logic [3:0]  speed,
    output logic [15:0] score,
    output logic        tick
);

    localparam int unsigned ScoreDivW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int unsigned HoldW     = $clog2(OVER_HOLD_TICKS + 1);
    localparam logic [ScoreDivW-1:0] ScoreDivLast = ScoreDivW'(SCORE_DIV - 1);
    localparam logic [HoldW-1:0]     HoldMax      = HoldW'(OVER_HOLD_TICKS);
    localparam logic [11:0]          Ground12     = 12'(GROUND_SIZE_X);
    localparam logic [3:0]           SpeedInit    = 4'(SPEED_INIT);
    localparam logic [3:0]           SpeedMax     = 4'(SPEED_MAX);

    game_state_e          state_q, state_d;
    logic                 btn_q;
    logic [10:0]          offset_pend_q, offset_pend_d;
    logic [10:0]          ground_offset_q, ground_offset_d;
    logic [3:0]           speed_q, speed_d;
    logic [15:0]          score_q, score_d;
    logic [ScoreDivW-1:0] score_div_q, score_div_d;
    logic [HoldW-1:0]     hold_q, hold_d;

    logic        press;
    logic [11:0] sum;
    logic [10:0] offset_next;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign press = btn_start & ~btn_q;

    // Scroll step with exact modular wrap of the remainder.
    always_comb begin
        sum         = {1'b0, offset_pend_q} + {8'b0, speed_q};
        offset_next = (sum >= Ground12) ? 11'(sum - Ground12) : sum[10:0];
    end

    // Next-state for the game FSM, offset, score and lockout counter.
    always_comb begin
        state_d       = state_q;
        offset_pend_d = offset_pend_q;
        speed_d       = speed_q;
        score_d       = score_q;
        score_div_d   = score_div_q;
        hold_d        = hold_q;
        // Frame-aligned publication; uses the pre-tick pending value.
        ground_offset_d = frame_start ? offset_pend_q : ground_offset_q;

        case (state_q)
            GameInitial: begin
                if (press) begin
                    state_d       = GamePlaying;
                    offset_pend_d = '0;
                    score_d       = '0;
                    score_div_d   = '0;
                    speed_d       = SpeedInit;
                end
            end
            GamePlaying: begin
                // Collision wins over a coincident tick.
                if (collision) begin
                    state_d = GameOver;
                    hold_d  = '0;
                end else if (tick) begin
                    offset_pend_d = offset_next;
                    if (score_div_q == ScoreDivLast) begin
                        score_div_d = '0;
                        if (score_q != 16'h9999) begin
                            score_d = bcd_inc(score_q);
                            // Carry into the hundreds digit bumps the speed.
                            if (score_q[7:0] == 8'h99 && speed_q < SpeedMax) begin
                                speed_d = speed_q + 4'd1;
                            end
                        end
                    end else begin
                        score_div_d = score_div_q + ScoreDivW'(1);
                    end
                end
            end
            GameOver: begin
                if (tick && hold_q != HoldMax) begin
                    hold_d = hold_q + HoldW'(1);
                end
                // Presses during the lockout window are simply dropped.
                if (press && hold_q == HoldMax) begin
                    state_d       = GamePlaying;
                    offset_pend_d = '0;
                    score_d       = '0;
                    score_div_d   = '0;
                    speed_d       = SpeedInit;
                end
            end
            default: state_d = GameInitial;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= GameInitial;
            btn_q           <= 1'b0;
            offset_pend_q   <= '0;
            ground_offset_q <= '0;
            speed_q         <= SpeedInit;
            score_q         <= '0;
            score_div_q     <= '0;
            hold_q          <= '0;
        end else begin
            state_q         <= state_d;
            btn_q           <= btn_start;
            offset_pend_q   <= offset_pend_d;
            ground_offset_q <= ground_offset_d;
            speed_q         <= speed_d;
            score_q         <= score_d;
            score_div_q     <= score_div_d;
            hold_q          <= hold_d;
        end
    end

    assign game_state    = state_q;
    assign ground_offset = ground_offset_q;
    assign speed         = speed_q;
    assign score         = score_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed self-checking bench for scene_sequencer.
module tb_scene_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_start = 1'b0;
    logic        collision = 1'b0;
    logic        frame_start;
    logic        fs_manual_mode = 1'b0;
    logic        fs_manual = 1'b0;
    logic [1:0]  game_state;
    logic [10:0] ground_offset;
    logic [3:0]  speed;
    logic [15:0] score;
    logic        tick;

    // Fast instance for score saturation.
    logic        rst2_n = 1'b0;
    logic        btn2 = 1'b0;
    logic [1:0]  s2_state;
    logic [10:0] s2_offset;
    logic [3:0]  s2_speed;
    logic [15:0] s2_score;
    logic        s2_tick;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign frame_start = fs_manual_mode ? fs_manual : tick;

    scene_sequencer #(
        .TICK_DIV (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_start     (btn_start),
        .collision     (collision),
        .frame_start   (frame_start),
        .game_state    (game_state),
        .ground_offset (ground_offset),
        .speed         (speed),
        .score         (score),
        .tick          (tick)
    );

    scene_sequencer #(
        .TICK_DIV  (2),
        .SCORE_DIV (1)
    ) dut2 (
        .clk           (clk),
        .rst_n         (rst2_n),
        .btn_start     (btn2),
        .collision     (1'b0),
        .frame_start   (s2_tick),
        .game_state    (s2_state),
        .ground_offset (s2_offset),
        .speed         (s2_speed),
        .score         (s2_score),
        .tick          (s2_tick)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic press();
        btn_start = 1'b1;
        @(posedge clk);
        #1;
        btn_start = 1'b0;
    endtask

    // Returns #1 after the edge that consumes the next tick pulse.
    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (!tick && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!tick) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout: tick=%0b required 1", tick);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        btn_start = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 5;
        if (game_state !== 2'd0) begin
            miscompares++; $display("FAIL reset_state: got %0d want 0", game_state);
        end
        if (ground_offset !== 11'd0) begin
            miscompares++; $display("FAIL reset_offset: got %0d want 0", ground_offset);
        end
        if (speed !== 4'd3) begin
            miscompares++; $display("FAIL reset_speed: got %0d want 3", speed);
        end
        if (score !== 16'h0000) begin
            miscompares++; $display("FAIL reset_score: got %h want 0000", score);
        end
        if (tick !== 1'b0) begin
            miscompares++; $display("FAIL reset_tick: got %0b want 0", tick);
        end
        rst_n     = 1'b1;
        btn_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (game_state !== 2'd0) begin
            miscompares++; $display("FAIL reset_no_start: got %0d want 0", game_state);
        end
    endtask

    task automatic test_scroll();
        logic [10:0] exp_off;
        do_reset();
        press();
        vectors++;
        if (game_state !== 2'd1) begin
            miscompares++; $display("FAIL scroll_start: got %0d want 1", game_state);
        end
        for (int j = 1; j <= 401; j++) begin
            wait_tick();
            exp_off = 11'((3 * (j - 1)) % 1200);
            vectors++;
            if (ground_offset !== exp_off) begin
                miscompares++;
                $display("FAIL scroll_offset tick %0d: got %0d want %0d", j, ground_offset, exp_off);
            end
        end
    endtask

    task automatic test_score();
        do_reset();
        press();
        for (int j = 1; j <= 1000; j++) begin
            wait_tick();
            if (j == 9 || j == 10) begin
                vectors++;
                if (score !== ((j == 10) ? 16'h0001 : 16'h0000)) begin
                    miscompares++; $display("FAIL score_first tick %0d: got %h", j, score);
                end
            end
            if (j == 999) begin
                vectors += 2;
                if (score !== 16'h0099) begin
                    miscompares++; $display("FAIL score_999: got %h want 0099", score);
                end
                if (speed !== 4'd3) begin
                    miscompares++; $display("FAIL speed_999: got %0d want 3", speed);
                end
            end
        end
        vectors += 2;
        if (score !== 16'h0100) begin
            miscompares++; $display("FAIL score_1000: got %h want 0100", score);
        end
        if (speed !== 4'd4) begin
            miscompares++; $display("FAIL speed_1000: got %0d want 4", speed);
        end
    endtask

    // Pending offset parked at 1198 at speed 4 across a non-tick edge.
    task automatic test_wrap_force();
        wait_tick();
        @(posedge clk);
        #1;
        force dut.offset_pend_q = 11'd1198;
        force dut.speed_q       = 4'd4;
        @(posedge clk);
        #1;
        release dut.offset_pend_q;
        release dut.speed_q;
        wait_tick();
        vectors++;
        if (ground_offset !== 11'd1198) begin
            miscompares++; $display("FAIL wrap_pre: got %0d want 1198", ground_offset);
        end
        wait_tick();
        vectors++;
        if (ground_offset !== 11'd2) begin
            miscompares++; $display("FAIL wrap_remainder: got %0d want 2", ground_offset);
        end
    endtask

    task automatic test_collision();
        int n;
        do_reset();
        press();
        wait_tick();
        @(posedge clk);
        #1;
        force dut.offset_pend_q = 11'd300;
        force dut.score_q       = 16'h0042;
        @(posedge clk);
        #1;
        release dut.offset_pend_q;
        release dut.score_q;
        n = 0;
        @(negedge clk);
        while (!tick && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!tick) begin
            vectors++; miscompares++;
            $display("FAIL coll_tick_timeout: tick=%0b required 1", tick);
        end
        collision = 1'b1;
        @(posedge clk);
        #1;
        collision = 1'b0;
        vectors += 3;
        if (game_state !== 2'd2) begin
            miscompares++; $display("FAIL coll_state: got %0d want 2", game_state);
        end
        if (ground_offset !== 11'd300) begin
            miscompares++; $display("FAIL coll_offset: got %0d want 300", ground_offset);
        end
        if (score !== 16'h0042) begin
            miscompares++; $display("FAIL coll_score: got %h want 0042", score);
        end
        wait_tick();
        vectors += 2;
        if (ground_offset !== 11'd300) begin
            miscompares++; $display("FAIL coll_frozen_offset: got %0d want 300", ground_offset);
        end
        if (score !== 16'h0042) begin
            miscompares++; $display("FAIL coll_frozen_score: got %h want 0042", score);
        end
    endtask

    // Continues from test_collision: one OVER tick already consumed.
    task automatic test_lockout();
        repeat (9) wait_tick();
        press();
        vectors++;
        if (game_state !== 2'd2) begin
            miscompares++; $display("FAIL lock_10: got %0d want 2", game_state);
        end
        repeat (39) wait_tick();
        press();
        vectors++;
        if (game_state !== 2'd2) begin
            miscompares++; $display("FAIL lock_49: got %0d want 2", game_state);
        end
        wait_tick();
        press();
        vectors += 3;
        if (game_state !== 2'd1) begin
            miscompares++; $display("FAIL lock_50: got %0d want 1", game_state);
        end
        if (score !== 16'h0000) begin
            miscompares++; $display("FAIL restart_score: got %h want 0000", score);
        end
        if (speed !== 4'd3) begin
            miscompares++; $display("FAIL restart_speed: got %0d want 3", speed);
        end
        wait_tick();
        vectors++;
        if (ground_offset !== 11'd0) begin
            miscompares++; $display("FAIL restart_offset: got %0d want 0", ground_offset);
        end
    endtask

    task automatic test_tear_and_reset();
        int          tk;
        logic        fs_last;
        logic [10:0] exp_pub;
        do_reset();
        press();
        fs_manual_mode = 1'b1;
        fs_manual      = 1'b0;
        tk             = 0;
        exp_pub        = 11'd0;
        for (int c = 0; c < 120 && tk < 21; c++) begin
            @(negedge clk);
            fs_manual = tick && ((tk + 1) % 7 == 0);
            fs_last   = fs_manual;
            if (tick) tk++;
            @(posedge clk);
            #1;
            fs_manual = 1'b0;
            if (fs_last) exp_pub = 11'(3 * (tk - 1));
            vectors++;
            if (ground_offset !== exp_pub) begin
                miscompares++;
                $display("FAIL tear cycle %0d: got %0d want %0d", c, ground_offset, exp_pub);
            end
        end
        vectors++;
        if (tk != 21) begin
            miscompares++; $display("FAIL tear_ticks: got %0d want 21", tk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors += 5;
        if (game_state !== 2'd0) begin
            miscompares++; $display("FAIL midreset_state: got %0d want 0", game_state);
        end
        if (ground_offset !== 11'd0) begin
            miscompares++; $display("FAIL midreset_offset: got %0d want 0", ground_offset);
        end
        if (score !== 16'h0000) begin
            miscompares++; $display("FAIL midreset_score: got %h want 0000", score);
        end
        if (speed !== 4'd3) begin
            miscompares++; $display("FAIL midreset_speed: got %0d want 3", speed);
        end
        if (tick !== 1'b0) begin
            miscompares++; $display("FAIL midreset_tick: got %0b want 0", tick);
        end
        rst_n          = 1'b1;
        fs_manual_mode = 1'b0;
    endtask

    task automatic test_saturate();
        rst2_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst2_n = 1'b1;
        btn2   = 1'b1;
        @(posedge clk);
        #1;
        btn2 = 1'b0;
        vectors++;
        if (s2_state !== 2'd1) begin
            miscompares++; $display("FAIL sat_start: got %0d want 1", s2_state);
        end
        repeat (20500) @(posedge clk);
        #1;
        vectors += 2;
        if (s2_score !== 16'h9999) begin
            miscompares++; $display("FAIL sat_score: got %h want 9999", s2_score);
        end
        if (s2_speed !== 4'd8) begin
            miscompares++; $display("FAIL sat_speed: got %0d want 8", s2_speed);
        end
        repeat (200) @(posedge clk);
        #1;
        vectors += 2;
        if (s2_score !== 16'h9999) begin
            miscompares++; $display("FAIL sat_hold: got %h want 9999", s2_score);
        end
        if (s2_speed !== 4'd8) begin
            miscompares++; $display("FAIL sat_speed_cap: got %0d want 8", s2_speed);
        end
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_score();
        test_wrap_force();
        test_collision();
        test_lockout();
        test_tear_and_reset();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
